// File: rtl/iter_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider for the execute stage.
// Word mode works on the low 32 bits and sign-extends the result to XLEN.
module iter_muldiv_unit #(
  parameter int XLEN      = 64,
  parameter int STEP_BITS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic            is_signed,
  input  logic            cut,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN/STEP_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_t;

  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [1:0]        r_op;
  logic              r_cut, r_neg, r_rneg, r_spec;
  logic [XLEN-1:0]   r_x, r_y, r_rem;
  logic [XLEN-1:0]   r_spec_val, r_result;
  logic [2*XLEN-1:0] r_acc, r_mc;

  logic [XLEN-1:0]   w_a, w_b, w_abs_a, w_abs_b;
  logic [XLEN-1:0]   w_min, w_sv;
  logic              w_sa, w_sb, w_bz, w_ovf;
  logic              w_mz, w_special, w_accept;
  logic [CW-1:0]     w_cnt0;

  // Operand conditioning and accept-time special cases
  always_comb begin
    w_a = a;
    w_b = b;
    if (cut) begin
      w_a = is_signed ? {{(XLEN-32){a[31]}}, a[31:0]}
                      : {{(XLEN-32){1'b0}}, a[31:0]};
      w_b = is_signed ? {{(XLEN-32){b[31]}}, b[31:0]}
                      : {{(XLEN-32){1'b0}}, b[31:0]};
    end
    w_sa    = is_signed & w_a[XLEN-1];
    w_sb    = is_signed & w_b[XLEN-1];
    w_abs_a = w_sa ? -w_a : w_a;
    w_abs_b = w_sb ? -w_b : w_b;
    w_min   = cut ? {{(XLEN-31){1'b1}}, 31'b0}
                  : {1'b1, {(XLEN-1){1'b0}}};
    w_bz    = (w_b == '0);
    w_ovf   = is_signed & (w_a == w_min) & (&w_b);
    w_mz    = (w_a == '0) | w_bz;
    w_special = op[1] ? (w_bz | w_ovf) : w_mz;
    w_sv = '0;
    if (op[1] && w_bz)
      w_sv = op[0] ? w_a : '1;
    else if (op[1] && w_ovf)
      w_sv = op[0] ? '0 : w_a;
    if (cut)
      w_sv = {{(XLEN-32){w_sv[31]}}, w_sv[31:0]};
    w_cnt0 = cut ? CW'(32/STEP_BITS) : CW'(XLEN/STEP_BITS);
    w_accept = start & ~flush & (r_state == S_IDLE);
  end

  logic [2*XLEN-1:0] w_acc, w_mc, w_prod;
  logic [XLEN-1:0]   w_x, w_y, w_rem;
  logic [XLEN:0]     w_t;

  // One iteration: STEP_BITS multiplier or quotient bits
  always_comb begin
    w_acc = r_acc;
    w_mc  = r_mc;
    w_x   = r_x;
    w_y   = r_y;
    w_rem = r_rem;
    w_t   = '0;
    for (int k = 0; k < STEP_BITS; k++) begin
      if (r_op[1]) begin
        w_t = {w_rem, w_x[XLEN-1]};
        w_x = {w_x[XLEN-2:0], 1'b0};
        if (w_t >= {1'b0, r_y}) begin
          w_t    = w_t - {1'b0, r_y};
          w_x[0] = 1'b1;
        end
        w_rem = w_t[XLEN-1:0];
      end else begin
        if (w_y[0])
          w_acc = w_acc + w_mc;
        w_mc = w_mc << 1;
        w_y  = w_y >> 1;
      end
    end
  end

  logic [XLEN-1:0] w_q, w_r, w_raw, w_res;

  always_comb begin
    w_prod = r_neg ? -r_acc : r_acc;
    w_q    = r_neg ? -r_x : r_x;
    w_r    = r_rneg ? -r_rem : r_rem;
    if (r_op == 2'b11)
      w_raw = w_r;
    else if (r_op == 2'b10)
      w_raw = w_q;
    else if (r_op == 2'b01)
      w_raw = r_cut ? {{(XLEN-32){1'b0}}, w_prod[63:32]}
                    : w_prod[2*XLEN-1:XLEN];
    else
      w_raw = w_prod[XLEN-1:0];
    w_res = r_cut ? {{(XLEN-32){w_raw[31]}}, w_raw[31:0]}
                  : w_raw;
    if (r_spec)
      w_res = r_spec_val;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_accept)
          w_next = w_special ? S_FIN : S_CALC;
      S_CALC:
        if (flush)
          w_next = S_IDLE;
        else if (r_cnt == CW'(1))
          w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign busy   = (r_state != S_IDLE) | start;
  assign done   = (r_state == S_FIN) & ~flush;
  assign result = done ? w_res : r_result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_cut      <= 1'b0;
      r_neg      <= 1'b0;
      r_rneg     <= 1'b0;
      r_spec     <= 1'b0;
      r_spec_val <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_rem      <= '0;
      r_acc      <= '0;
      r_mc       <= '0;
      r_result   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op       <= op;
        r_cut      <= cut;
        r_spec     <= w_special;
        r_spec_val <= w_sv;
        r_neg      <= w_sa ^ w_sb;
        r_rneg     <= w_sa;
        r_cnt      <= w_cnt0;
        // Word divide: align the 32-bit dividend to the MSB
        r_x   <= (op[1] & cut) ? (w_abs_a << (XLEN-32)) : w_abs_a;
        r_y   <= w_abs_b;
        r_mc  <= {{XLEN{1'b0}}, w_abs_a};
        r_acc <= '0;
        r_rem <= '0;
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt - CW'(1);
        r_acc <= w_acc;
        r_mc  <= w_mc;
        r_x   <= w_x;
        r_y   <= w_y;
        r_rem <= w_rem;
      end else if (r_state == S_FIN) begin
        r_cnt <= '0;
      end
      if (done)
        r_result <= w_res;
    end
  end

endmodule
